gps_srq_sched: RTL
==================

Name: gps_srq_sched

Overview:
- Service-request scheduler for the GPS channel bank.
- Accumulates per-channel epoch requests (ms0 pulses) and the host request, and picks one requester per service cycle: round-robin among channels, host lowest priority.
- For a granted channel, it drives one-hot shift strobes that read out that channel's serial IQ/replica data, and packs the bits into 16-bit words for the CPU read path.
- Replaces per-bit CPU rdBit polling of GET_SRQ/GET_CHAN_IQ.

Parameters:
- GPS_CHANS, 12, number of demodulator channels (2..16).
- SHIFT_BITS, 96, serial bits read per channel service; must be a nonzero multiple of 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- chan_srq  in  GPS_CHANS  per-channel epoch pulses (1 cycle each).
- host_srq  in  1  host request, level.
- chan_mask  in  GPS_CHANS  1 = channel enabled for service.
- start  in  1  1-cycle pulse: begin one service cycle.
- chan_sout  in  GPS_CHANS  serial data from each channel, MSB first, valid before its shift.
- chan_shift  out  GPS_CHANS  one-hot shift strobe to the granted channel.
- busy  out  1  service cycle in progress.
- grant_chan  out  4  granted channel index.
- grant_host  out  1  current grant is the host.
- no_srq  out  1  1-cycle pulse: start seen with nothing pending.
- word  out  16  packed serial data.
- word_valid  out  1  1-cycle pulse: word holds 16 new bits.
- done  out  1  1-cycle pulse: service cycle complete.
- pending  out  GPS_CHANS  unserviced channel requests.
- overrun  out  GPS_CHANS  sticky: epoch arrived while already pending.

Behaviour:
- Reset values: all outputs 0; pending 0; overrun 0; last_grant = GPS_CHANS-1 (so channel 0 wins first); state IDLE.
- Pending update, every cycle:
  - pending[i] <= (pending[i] & ~clr[i]) | (chan_srq[i] & chan_mask[i]).
  - clr is the one-cycle clear issued in ARB for the granted channel.
  - Set wins over a simultaneous clear.
  - overrun[i] sets when chan_srq[i] & chan_mask[i] & pending[i] & ~clr[i]. Cleared only by rst.
- Masking: clearing chan_mask[i] does not drop an already-pending bit; it only blocks new sets.
- State IDLE:
  - start with pending==0 and host_srq==0: no_srq=1 next cycle, stay IDLE.
  - start otherwise: go to ARB.
  - start while busy: ignored.
- State ARB (1 cycle, busy=1):
  - Select the first set pending bit searching last_grant+1, +2, … with wrap at GPS_CHANS.
  - Register grant_chan, update last_grant, clear that pending bit, load bit counter = SHIFT_BITS, go to SHIFT.
  - If no channel is pending but host_srq=1: grant_host=1, grant_chan=0, go to DONE.
- State SHIFT (SHIFT_BITS cycles):
  - Each cycle: sr <= {sr[14:0], chan_sout[grant_chan]}; chan_shift = one-hot(grant_chan), asserted combinationally in the same cycle; counter decrements.
  - After every 16th bit: word <= completed sr value, word_valid pulses the following cycle.
  - When the counter reaches 0, go to DONE.
  - The final word_valid coincides with the DONE cycle.
- State DONE (1 cycle): done=1; grant_host cleared; go to IDLE. grant_chan holds its value until the next ARB.
- Latency: start at cycle T → ARB at T+1 → chan_shift asserted T+2 .. T+1+SHIFT_BITS → done at T+2+SHIFT_BITS. Host-only grant: done at T+2.
- chan_shift is 0 outside SHIFT; never more than one bit set.
- rst mid-SHIFT: state returns to IDLE immediately; chan_shift is 0 in the next cycle; a partial word is discarded, with no word_valid or done.
- chan_srq pulses arriving during SHIFT for the granted channel re-set its pending bit. That is legal: it counts as a new epoch, with no overrun.

Test Plan:
- Reset, chan_mask=0xFFF, pulse chan_srq[3] and chan_srq[7], then start → grant_chan=3. SHIFT_BITS=96 gives 96 chan_shift[3] pulses and 6 word_valid; done at start+98; pending=0x080.
- Round-robin: after the grant of 3, pending={1,7}, start → grant 7; next start → grant 1 (wrap); next start → no_srq pulse.
- Serial packing: chan_sout[5] drives the pattern 0xA5C3 repeating, chan 5 granted → every word equals 0xA5C3.
- Collision: chan_srq[2] pulses in the same cycle the ARB clear hits channel 2 → pending[2]=1, overrun[2]=0. A second pulse before service → overrun[2]=1.
- Host: pending=0, host_srq=1, start → grant_host=1, no chan_shift, done at start+2. With pending[0]=1 as well → channel 0 is granted first.
- Mask and reset: chan_mask[4]=0, pulse chan_srq[4] → pending[4]=0. Assert rst at the 40th SHIFT cycle → chan_shift=0 next cycle, busy=0, no further word_valid or done.

Source files
------------

// File: rtl/gps_srq_sched.sv
// Service-request scheduler for the GPS channel bank: collects channel epoch and
// host requests, grants one requester per service cycle and packs serial IQ into 16-bit words.
module gps_srq_sched #(
    parameter int GPS_CHANS  = 12,
    parameter int SHIFT_BITS = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [GPS_CHANS-1:0] chan_srq,
    input  logic                 host_srq,
    input  logic [GPS_CHANS-1:0] chan_mask,
    input  logic                 start,
    input  logic [GPS_CHANS-1:0] chan_sout,
    output logic [GPS_CHANS-1:0] chan_shift,
    output logic                 busy,
    output logic [3:0]           grant_chan,
    output logic                 grant_host,
    output logic                 no_srq,
    output logic [15:0]          word,
    output logic                 word_valid,
    output logic                 done,
    output logic [GPS_CHANS-1:0] pending,
    output logic [GPS_CHANS-1:0] overrun
);

    localparam int CNT_W = $clog2(SHIFT_BITS + 1);
    localparam logic [GPS_CHANS-1:0] CHAN_ONE = GPS_CHANS'(1);

    typedef enum logic [1:0] {
        IDLE,
        ARB,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [GPS_CHANS-1:0] pending_q;
    logic [GPS_CHANS-1:0] overrun_q;
    logic [3:0]           last_grant_q;
    logic [3:0]           grant_chan_q;
    logic                 grant_host_q;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [14:0]          sr_q;
    logic [15:0]          word_q;
    logic                 word_valid_q;
    logic                 no_srq_q;

    logic                 arb_found;
    logic [3:0]           arb_idx;
    logic [4:0]           cand;
    logic [GPS_CHANS-1:0] set_req;
    logic [GPS_CHANS-1:0] clr;
    logic                 sout_bit;
    logic                 word_end;
    logic                 any_req;

    assign set_req  = chan_srq & chan_mask;
    assign clr      = (state_q == ARB && arb_found) ? (CHAN_ONE << arb_idx) : '0;
    assign sout_bit = chan_sout[grant_chan_q];
    // The counter runs SHIFT_BITS..1, so a value of 1 mod 16 marks the 16th bit of a word.
    assign word_end = (bit_cnt_q[3:0] == 4'd1);
    assign any_req  = (|pending_q) | host_srq;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= GPS_CHANS; k++) begin
            cand = {1'b0, last_grant_q} + 5'(k);
            if (cand >= 5'(GPS_CHANS)) begin
                cand = cand - 5'(GPS_CHANS);
            end
            if (!arb_found && pending_q[cand[3:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[3:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && any_req) state_d = ARB;
            ARB:     state_d = arb_found ? SHIFT : DONE;
            SHIFT:   if (bit_cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            overrun_q    <= '0;
            last_grant_q <= 4'(GPS_CHANS - 1);
            grant_chan_q <= '0;
            grant_host_q <= 1'b0;
            bit_cnt_q    <= '0;
            sr_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            no_srq_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples the pre-edge values, independent of statement order.
            state_q      <= state_d;
            pending_q    <= (pending_q & ~clr) | set_req;
            overrun_q    <= overrun_q | (set_req & pending_q & ~clr);
            no_srq_q     <= (state_q == IDLE) && start && !any_req;
            word_valid_q <= 1'b0;
            case (state_q)
                ARB: begin
                    bit_cnt_q <= CNT_W'(SHIFT_BITS);
                    if (arb_found) begin
                        grant_chan_q <= arb_idx;
                        last_grant_q <= arb_idx;
                    end else if (host_srq) begin
                        grant_host_q <= 1'b1;
                        grant_chan_q <= '0;
                    end
                end
                SHIFT: begin
                    sr_q      <= {sr_q[13:0], sout_bit};
                    bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                    if (word_end) begin
                        word_q       <= {sr_q, sout_bit};
                        word_valid_q <= 1'b1;
                    end
                end
                DONE:    grant_host_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign chan_shift = (state_q == SHIFT) ? (CHAN_ONE << grant_chan_q) : '0;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign grant_chan = grant_chan_q;
    assign grant_host = grant_host_q;
    assign no_srq     = no_srq_q;
    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule
